// File: rtl/collator_pkg.sv
// Shared constants, types and helpers for the sign-bit collator.
// The mb_conf field offsets, group count, buffer depth and default SEED/MULT are defined here.
package collator_pkg;

  localparam int NUM_GROUPS = 7;
  localparam int DEPTH      = 64;
  localparam int CNT_W      = 7;
  localparam int GRP_W      = 3;
  localparam int KEY_W      = 6;

  localparam logic [KEY_W-1:0] SEED_DEFAULT = 6'h01;
  localparam int               MULT_DEFAULT = 37;

  localparam int CONF_W           = 91;
  localparam int OVF_BIT          = 90;
  localparam int LAST_GROUP_LSB   = 87;
  localparam int PLAINNUM_M_LSB   = 84;
  localparam int FIELD_STRIDE     = 14;
  localparam int PLAINNUM_OFS     = 7;
  localparam int NON_PLAINNUM_OFS = 0;

  localparam logic [GRP_W-1:0] EMPTY_TAG = 3'd7;
  localparam logic [GRP_W-1:0] MAX_GROUP = 3'd6;
  localparam logic [GRP_W-1:0] PM_MAX    = 3'd7;
  localparam logic [CNT_W-1:0] CNT_MAX   = 7'h7f;
  localparam logic [CNT_W-1:0] DEPTH_CNT = 7'd64;

  typedef logic [NUM_GROUPS-2:0][CNT_W-1:0] cnt_arr_t;
  typedef logic [0:DEPTH-1][GRP_W-1:0]      tag_arr_t;
  typedef logic [0:DEPTH-1][KEY_W-1:0]      pos_arr_t;

  // Fibonacci LFSR for x^6 + x^5 + 1
  function automatic logic [KEY_W-1:0] lfsr_next(input logic [KEY_W-1:0] k);
    return {k[4:0], k[5] ^ k[4]};
  endfunction

  function automatic logic [KEY_W-1:0] scramble_pos(input int mult, input int i,
                                                    input logic [KEY_W-1:0] key);
    int t;
    t = mult * i + int'(key);
    return t[KEY_W-1:0];
  endfunction

  function automatic pos_arr_t seed_map(input logic [KEY_W-1:0] key, input int mult);
    pos_arr_t m;
    m = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = scramble_pos(mult, i, key);
    end
    return m;
  endfunction

  function automatic logic [CONF_W-1:0] pack_conf(input logic             ovf,
                                                  input logic [GRP_W-1:0] last_g,
                                                  input logic [GRP_W-1:0] pm,
                                                  input cnt_arr_t         pn,
                                                  input cnt_arr_t         np);
    logic [CONF_W-1:0] c;
    c = '0;
    c[OVF_BIT] = ovf;
    c[LAST_GROUP_LSB +: GRP_W] = last_g;
    c[PLAINNUM_M_LSB +: GRP_W] = pm;
    for (int k = 0; k < NUM_GROUPS - 1; k++) begin
      c[k*FIELD_STRIDE + PLAINNUM_OFS +: CNT_W]     = pn[k];
      c[k*FIELD_STRIDE + NON_PLAINNUM_OFS +: CNT_W] = np[k];
    end
    return c;
  endfunction

endpackage

// File: rtl/collator_scrambler.sv
// Key-driven permutation and gather of the collected sign bits and their group tags.
// Output lane i reads buffer slot (MULT*i + key) mod 64, or reports empty past the fill level.
module collator_scrambler
  import collator_pkg::*;
#(
  parameter int MULT = MULT_DEFAULT
) (
  input  logic [KEY_W-1:0] i_key,
  input  logic [DEPTH-1:0] i_buf,
  input  tag_arr_t         i_tag,
  input  logic [CNT_W-1:0] i_n,
  output logic [DEPTH-1:0] o_plaintext,
  output logic [CNT_W-1:0] o_count,
  output tag_arr_t         o_group,
  output pos_arr_t         o_position
);

  pos_arr_t         w_pos;
  logic [DEPTH-1:0] w_valid;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lane
    assign w_pos[gi]       = scramble_pos(MULT, gi, i_key);
    assign w_valid[gi]     = ({1'b0, w_pos[gi]} < i_n);
    assign o_plaintext[gi] = w_valid[gi] ? i_buf[w_pos[gi]] : 1'b0;
    assign o_group[gi]     = w_valid[gi] ? i_tag[w_pos[gi]] : EMPTY_TAG;
  end

  assign o_position = w_pos;
  assign o_count    = i_n;

endmodule

// File: rtl/collator.sv
// Collects group-tagged sign bits per macroblock, counts them per group, and on close
// publishes a configuration word plus a scrambled view of the collected bits.
module collator
  import collator_pkg::*;
#(
  parameter logic [KEY_W-1:0] SEED = SEED_DEFAULT,
  parameter int               MULT = MULT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              sign_en,
  input  logic              sign_bit,
  input  logic              group_change,
  input  logic              macroblock_end,
  input  logic              slice_end,
  output logic [CONF_W-1:0] mb_conf,
  output logic              mb_wr,
  output logic              mb_conf_wr,
  output logic [DEPTH-1:0]  scrambled_plaintext,
  output logic [CNT_W-1:0]  scrambled_count,
  output tag_arr_t          scrambled_group,
  output pos_arr_t          original_position
);

  localparam pos_arr_t SEED_POS = seed_map(SEED, MULT);

  logic [DEPTH-1:0] r_buf;
  tag_arr_t         r_tag;
  logic [CNT_W-1:0] r_n;
  logic [GRP_W-1:0] r_g;
  logic [GRP_W-1:0] r_pm;
  cnt_arr_t         r_pn;
  cnt_arr_t         r_np;
  logic             r_ovf;
  logic [KEY_W-1:0] r_key;

  logic [CONF_W-1:0] r_conf;
  logic [DEPTH-1:0]  r_sp;
  logic [CNT_W-1:0]  r_sc;
  tag_arr_t          r_sg;
  pos_arr_t          r_op;
  logic              r_mbwr;
  logic              r_cwr;

  logic [DEPTH-1:0] w_buf;
  tag_arr_t         w_tag;
  logic [CNT_W-1:0] w_n;
  logic [GRP_W-1:0] w_g;
  logic [GRP_W-1:0] w_gi;
  logic [GRP_W-1:0] w_pm;
  cnt_arr_t         w_pn;
  cnt_arr_t         w_np;
  logic             w_ovf;
  logic             w_close;

  logic [DEPTH-1:0] w_sp;
  logic [CNT_W-1:0] w_sc;
  tag_arr_t         w_sg;
  pos_arr_t         w_op;

  assign w_close = macroblock_end | slice_end;
  assign w_gi    = r_g - 3'd1;
  assign w_g     = (group_change && (r_g != MAX_GROUP)) ? r_g + 3'd1 : r_g;

  // The incoming bit is accounted against the current group before any group or close update.
  always_comb begin
    w_buf = r_buf;
    w_tag = r_tag;
    w_n   = r_n;
    w_pm  = r_pm;
    w_pn  = r_pn;
    w_np  = r_np;
    w_ovf = r_ovf;
    if (sign_en) begin
      if (r_n < DEPTH_CNT) begin
        w_buf[r_n[KEY_W-1:0]] = sign_bit;
        w_tag[r_n[KEY_W-1:0]] = r_g;
        w_n = r_n + 7'd1;
        if (r_g == 3'd0) begin
          if (r_pm != PM_MAX) begin
            w_pm = r_pm + 3'd1;
          end
        end else if (r_pn[w_gi] != CNT_MAX) begin
          w_pn[w_gi] = r_pn[w_gi] + 7'd1;
        end
      end else begin
        w_ovf = 1'b1;
        if ((r_g != 3'd0) && (r_np[w_gi] != CNT_MAX)) begin
          w_np[w_gi] = r_np[w_gi] + 7'd1;
        end
      end
    end
  end

  collator_scrambler #(
    .MULT(MULT)
  ) u_scrambler (
    .i_key      (r_key),
    .i_buf      (w_buf),
    .i_tag      (w_tag),
    .i_n        (w_n),
    .o_plaintext(w_sp),
    .o_count    (w_sc),
    .o_group    (w_sg),
    .o_position (w_op)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf <= '0;
      r_tag <= '0;
      r_n   <= '0;
      r_g   <= '0;
      r_pm  <= '0;
      r_pn  <= '0;
      r_np  <= '0;
      r_ovf <= 1'b0;
      r_key <= SEED;
    end else if (clk_en) begin
      if (w_close) begin
        r_buf <= '0;
        r_tag <= '0;
        r_n   <= '0;
        r_g   <= '0;
        r_pm  <= '0;
        r_pn  <= '0;
        r_np  <= '0;
        r_ovf <= 1'b0;
        r_key <= slice_end ? SEED : lfsr_next(r_key);
      end else begin
        r_buf <= w_buf;
        r_tag <= w_tag;
        r_n   <= w_n;
        r_g   <= w_g;
        r_pm  <= w_pm;
        r_pn  <= w_pn;
        r_np  <= w_np;
        r_ovf <= w_ovf;
      end
    end
  end

  // Published results hold between closes; the write strobes are single-cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_conf <= '0;
      r_sp   <= '0;
      r_sc   <= '0;
      r_sg   <= {DEPTH{EMPTY_TAG}};
      r_op   <= SEED_POS;
      r_mbwr <= 1'b0;
      r_cwr  <= 1'b0;
    end else begin
      r_cwr  <= clk_en & w_close;
      r_mbwr <= clk_en & w_close & (w_n != '0);
      if (clk_en && w_close) begin
        r_conf <= pack_conf(w_ovf, r_g, w_pm, w_pn, w_np);
        r_sp   <= w_sp;
        r_sc   <= w_sc;
        r_sg   <= w_sg;
        r_op   <= w_op;
      end
    end
  end

  assign mb_conf             = r_conf;
  assign mb_wr               = r_mbwr;
  assign mb_conf_wr          = r_cwr;
  assign scrambled_plaintext = r_sp;
  assign scrambled_count     = r_sc;
  assign scrambled_group     = r_sg;
  assign original_position   = r_op;

endmodule

// File: tb/tb_collator.sv
// Randomized and directed bench for the collator against a queue-based model of a macroblock.
module tb_collator;

  localparam int         M_MULT = 37;
  localparam logic [5:0] M_SEED = 6'h01;

  logic clk = 1'b0;
  logic rst;
  logic clk_en, sign_en, sign_bit, group_change, macroblock_end, slice_end;
  logic [90:0]      mb_conf;
  logic             mb_wr, mb_conf_wr;
  logic [63:0]      scrambled_plaintext;
  logic [6:0]       scrambled_count;
  logic [0:63][2:0] scrambled_group;
  logic [0:63][5:0] original_position;

  int nCompared = 0;
  int nMismatched = 0;

  bit         qBits[$];
  int         qGrp[$];
  int         disc[7];
  int         mGroup;
  logic [5:0] mKey;

  logic [90:0]      eConf;
  logic [63:0]      eSp;
  logic [6:0]       eSc;
  logic [0:63][2:0] eSg;
  logic [0:63][5:0] eOp;
  logic             eMbWr, eConfWr;

  int litPn[6];
  int litNp[6];

  collator dut (
    .clk                (clk),
    .rst                (rst),
    .clk_en             (clk_en),
    .sign_en            (sign_en),
    .sign_bit           (sign_bit),
    .group_change       (group_change),
    .macroblock_end     (macroblock_end),
    .slice_end          (slice_end),
    .mb_conf            (mb_conf),
    .mb_wr              (mb_wr),
    .mb_conf_wr         (mb_conf_wr),
    .scrambled_plaintext(scrambled_plaintext),
    .scrambled_count    (scrambled_count),
    .scrambled_group    (scrambled_group),
    .original_position  (original_position)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic logic [5:0] nextKey(input logic [5:0] k);
    int fb;
    fb = ((int'(k) >> 5) ^ (int'(k) >> 4)) & 1;
    return 6'(((int'(k) << 1) | fb) & 63);
  endfunction

  function automatic int pnOf(input int k);
    return int'(mb_conf[14*k+7 +: 7]);
  endfunction

  function automatic int npOf(input int k);
    return int'(mb_conf[14*k +: 7]);
  endfunction

  task automatic cmp(input string name, input logic [383:0] act, input logic [383:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkLit(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic resetModel();
    qBits.delete();
    qGrp.delete();
    for (int g = 0; g < 7; g++) disc[g] = 0;
    mGroup  = 0;
    mKey    = M_SEED;
    eConf   = '0;
    eSp     = '0;
    eSc     = '0;
    eMbWr   = 1'b0;
    eConfWr = 1'b0;
    for (int i = 0; i < 64; i++) begin
      eSg[i] = 3'd7;
      eOp[i] = 6'((M_MULT * i + int'(M_SEED)) % 64);
    end
  endtask

  task automatic closeModel(input bit isSlice);
    int n;
    int stored[7];
    int totalDisc;
    int p;
    n = qBits.size();
    totalDisc = 0;
    for (int g = 0; g < 7; g++) begin
      stored[g] = 0;
      totalDisc += disc[g];
    end
    foreach (qGrp[i]) stored[qGrp[i]]++;
    eConf = '0;
    eConf[90] = (totalDisc > 0);
    eConf[87 +: 3] = 3'(mGroup);
    eConf[84 +: 3] = 3'(sat(stored[0], 7));
    for (int k = 0; k < 6; k++) begin
      eConf[14*k+7 +: 7] = 7'(sat(stored[k+1], 127));
      eConf[14*k +: 7]   = 7'(sat(disc[k+1], 127));
    end
    for (int i = 0; i < 64; i++) begin
      p = (M_MULT * i + int'(mKey)) % 64;
      eOp[i] = 6'(p);
      if (p < n) begin
        eSp[i] = qBits[p];
        eSg[i] = 3'(qGrp[p]);
      end else begin
        eSp[i] = 1'b0;
        eSg[i] = 3'd7;
      end
    end
    eSc     = 7'(n);
    eMbWr   = (n != 0);
    eConfWr = 1'b1;
    qBits.delete();
    qGrp.delete();
    for (int g = 0; g < 7; g++) disc[g] = 0;
    mGroup = 0;
    mKey   = isSlice ? M_SEED : nextKey(mKey);
  endtask

  task automatic checkOutput();
    cmp("mb_conf_wr", 384'(mb_conf_wr), 384'(eConfWr));
    cmp("mb_wr", 384'(mb_wr), 384'(eMbWr));
    cmp("mb_conf", 384'(mb_conf), 384'(eConf));
    cmp("scrambled_plaintext", 384'(scrambled_plaintext), 384'(eSp));
    cmp("scrambled_count", 384'(scrambled_count), 384'(eSc));
    cmp("scrambled_group", 384'(scrambled_group), 384'(eSg));
    cmp("original_position", 384'(original_position), 384'(eOp));
  endtask

  // One clock of stimulus: drive, advance the model, then check just after the edge.
  task automatic applyStimulus(input bit en, input bit se, input bit sb, input bit gc,
                               input bit me, input bit sl);
    clk_en         = en;
    sign_en        = se;
    sign_bit       = sb;
    group_change   = gc;
    macroblock_end = me;
    slice_end      = sl;
    eMbWr   = 1'b0;
    eConfWr = 1'b0;
    if (en) begin
      if (se) begin
        if (qBits.size() < 64) begin
          qBits.push_back(sb);
          qGrp.push_back(mGroup);
        end else begin
          disc[mGroup]++;
        end
      end
      if (me || sl) closeModel(sl);
      else if (gc && mGroup < 6) mGroup++;
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic runMacroblock(input int c0, input int c1, input int c2, input int c3,
                               input int c4, input int c5, input int c6, input bit useSlice);
    int cnt[7];
    cnt = '{c0, c1, c2, c3, c4, c5, c6};
    for (int g = 0; g < 7; g++) begin
      for (int b = 0; b < cnt[g]; b++) applyStimulus(1, 1, 1'($urandom_range(0, 1)), 0, 0, 0);
      if (g < 6) applyStimulus(1, 0, 0, 1, 0, 0);
    end
    applyStimulus(1, 0, 0, 0, !useSlice, useSlice);
  endtask

  task automatic checkCounts(input string tag, input int pm, input int cnt, input int ovf);
    checkLit({tag, "_plainnum_m"}, int'(mb_conf[86:84]), pm);
    for (int k = 0; k < 6; k++) begin
      checkLit($sformatf("%s_plainnum%0d", tag, k), pnOf(k), litPn[k]);
      checkLit($sformatf("%s_non_plainnum%0d", tag, k), npOf(k), litNp[k]);
    end
    checkLit({tag, "_count"}, int'(scrambled_count), cnt);
    checkLit({tag, "_overflow"}, int'(mb_conf[90]), ovf);
    checkLit({tag, "_conf_wr"}, int'(mb_conf_wr), 1);
    checkLit({tag, "_mb_wr"}, int'(mb_wr), (cnt != 0) ? 1 : 0);
  endtask

  task automatic runRandom(input int numMb);
    int len;
    bit en, se, gc, me, sl;
    for (int m = 0; m < numMb; m++) begin
      len = $urandom_range(0, 160);
      for (int c = 0; c < len; c++) begin
        en = ($urandom_range(0, 9) != 0);
        se = ($urandom_range(0, 9) < 7);
        gc = ($urandom_range(0, 9) == 0);
        me = en ? 1'b0 : ($urandom_range(0, 2) == 0);
        sl = en ? 1'b0 : ($urandom_range(0, 4) == 0);
        applyStimulus(en, se, 1'($urandom_range(0, 1)), gc, me, sl);
      end
      applyStimulus(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
                    1, ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    int rebuilt[64];
    int expTags[13];
    logic [0:63][2:0] allSeven;

    rst = 1'b1;
    clk_en = 0; sign_en = 0; sign_bit = 0; group_change = 0; macroblock_end = 0; slice_end = 0;
    #1 rst = 1'b0;
    resetModel();
    #1 checkOutput();
    checkLit("reset_pos0", int'(original_position[0]), 1);
    checkLit("reset_pos1", int'(original_position[1]), 38);
    @(posedge clk);
    #1 rst = 1'b1;

    // First macroblock after reset uses key 1; inverting the permutation restores tag order.
    runMacroblock(2, 3, 1, 0, 4, 2, 1, 0);
    checkLit("r32_pos0", int'(original_position[0]), 1);
    checkLit("r32_pos1", int'(original_position[1]), 38);
    checkLit("r32_count", int'(scrambled_count), 13);
    for (int i = 0; i < 64; i++) rebuilt[original_position[i]] = int'(scrambled_group[i]);
    expTags = '{0, 0, 1, 1, 1, 2, 4, 4, 4, 4, 5, 5, 6};
    for (int p = 0; p < 13; p++) checkLit($sformatf("r32_tag%0d", p), rebuilt[p], expTags[p]);
    checkLit("r32_tag_empty", rebuilt[13], 7);

    runMacroblock(0, 3, 4, 0, 31, 2, 50, 0);
    litPn = '{3, 4, 0, 31, 2, 24};
    litNp = '{0, 0, 0, 0, 0, 26};
    checkCounts("r29", 0, 64, 1);
    checkLit("r29_last_group", int'(mb_conf[89:87]), 6);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkLit("r29_conf_wr_drop", int'(mb_conf_wr), 0);
    checkLit("r29_mb_wr_drop", int'(mb_wr), 0);

    runMacroblock(4, 64, 64, 64, 64, 64, 64, 0);
    litPn = '{60, 0, 0, 0, 0, 0};
    litNp = '{4, 64, 64, 64, 64, 64};
    checkCounts("r30", 4, 64, 1);

    runMacroblock(0, 11, 11, 11, 11, 11, 11, 1);
    litPn = '{11, 11, 11, 11, 11, 9};
    litNp = '{0, 0, 0, 0, 0, 2};
    checkCounts("r31", 0, 64, 1);

    // Slice close reloaded the key, so this empty macroblock maps with key 1 again.
    runMacroblock(0, 0, 0, 0, 0, 0, 0, 0);
    litPn = '{0, 0, 0, 0, 0, 0};
    litNp = '{0, 0, 0, 0, 0, 0};
    checkCounts("r33", 0, 0, 0);
    allSeven = {64{3'd7}};
    cmp("r33_groups", 384'(scrambled_group), 384'(allSeven));
    checkLit("r33_pos1", int'(original_position[1]), 38);

    runMacroblock(12, 0, 0, 0, 0, 0, 0, 0);
    checkCounts("pm_sat", 7, 12, 0);

    for (int c = 0; c < 3; c++) applyStimulus(0, 1, 1, 0, 1, 0);
    checkLit("r34_conf_wr", int'(mb_conf_wr), 0);
    checkLit("r34_mb_wr", int'(mb_wr), 0);
    runMacroblock(1, 0, 0, 0, 0, 0, 0, 0);
    checkCounts("r34", 1, 1, 0);

    for (int c = 0; c < 10; c++) applyStimulus(1, 1, 1, 0, 0, 0);
    rst = 1'b0;
    #2;
    resetModel();
    checkOutput();
    @(posedge clk);
    #1 rst = 1'b1;
    checkOutput();
    applyStimulus(1, 0, 0, 0, 1, 0);
    checkLit("r26_count", int'(scrambled_count), 0);
    checkLit("r26_mb_wr", int'(mb_wr), 0);

    runRandom(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/collator.md
COLLATOR -- requirements
Module: collator

Interface
REQ-001 SHALL have parameters: SEED, default 6'h01, initial/slice scramble key; MULT, default 37 (odd), scramble multiplier.
REQ-002 SHALL have ports: clk, input, 1, single clock, rising edge.
REQ-003 SHALL have ports: rst, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have ports: clk_en, input, 1, clock enable; no state changes when 0.
REQ-005 SHALL have ports: sign_en, input, 1, sign_bit valid this cycle.
REQ-006 SHALL have ports: sign_bit, input, 1, sign bit to collect.
REQ-007 SHALL have ports: group_change, input, 1, advance to next group.
REQ-008 SHALL have ports: macroblock_end, input, 1, close macroblock.
REQ-009 SHALL have ports: slice_end, input, 1, close macroblock and restart scramble key.
REQ-010 SHALL have ports: mb_conf, output, 91, {overflow[90], last_group[89:87], plainnum_m[86:84], then plainnum[k],non_plainnum[k] 7b each for k=5 down to 0}.
REQ-011 SHALL have ports: mb_wr, output, 1, scrambled data valid pulse.
REQ-012 SHALL have ports: mb_conf_wr, output, 1, mb_conf valid pulse.
REQ-013 SHALL have ports: scrambled_plaintext, output, 64; scrambled_count, output, 7; scrambled_group, output, packed [0:63][2:0]; original_position, output, packed [0:63][5:0].

Function
REQ-014 SHALL keep a 3-bit group index g, 0 at macroblock start; group_change increments g, saturating at 6.
REQ-015 On each clk_en&sign_en cycle, SHALL store sign_bit and tag g at buffer position n (n = stored count) when n<64, then increment n; otherwise the bit is discarded.
REQ-016 Group 0 stored bits SHALL count into plainnum_m (saturating 7); group-0 discarded bits SHALL not be counted.
REQ-017 Group k (1..6) stored bits SHALL count into plainnum[k-1]; discarded bits into non_plainnum[k-1]; both saturate at 127.
REQ-018 sign_en coincident with group_change SHALL credit the bit to the old group; coincident with macroblock_end/slice_end SHALL include it in the closing macroblock.
REQ-019 On clk_en&(macroblock_end|slice_end), next edge SHALL register mb_conf, scrambled outputs, scrambled_count=n, and pulse mb_conf_wr for one cycle; mb_wr pulses the same cycle only if n!=0.
REQ-020 overflow SHALL be 1 iff any bit was discarded; last_group SHALL be g at close.
REQ-021 SHALL compute original_position[i] = (MULT*i + key) mod 64; scrambled_plaintext[i] and scrambled_group[i] take buffer[original_position[i]]; if original_position[i] >= n, plaintext bit 0 and group 3'd7.
REQ-022 key SHALL be a 6-bit LFSR (x^6+x^5+1), advancing once per macroblock close; slice_end reloads SEED after output.
REQ-023 After a close, all counters, n, g and tags SHALL clear; outputs hold until next close.
REQ-024 When clk_en=0, every register SHALL hold and pulses SHALL not assert.

Reset
REQ-025 rst low SHALL asynchronously clear counters, n, g, buffer, mb_conf, scrambled_plaintext, scrambled_count, mb_wr, mb_conf_wr to 0, scrambled_group to all 7, key to SEED, original_position to the SEED mapping.
REQ-026 Reset mid-macroblock SHALL discard partial data with no output pulse.

Structure
REQ-027 mb_conf field offsets, group count (7), buffer depth (64), SEED/MULT defaults SHALL reside in a shared package collator_pkg.
REQ-028 The permutation/gather SHALL be one sub-module, collator_scrambler (key, buffer, tags, n in; four scrambled outputs out).

Verification
REQ-029 Groups 0,3,4,0,31,2,50 then macroblock_end -> plainnum_m=0, plainnum[0..5]=3,4,0,31,2,24, non_plainnum[5]=26, others 0, count=64, overflow=1, mb_wr=mb_conf_wr=1 one cycle.
REQ-030 Groups 4,64×6 -> plainnum_m=4, plainnum[0]=60, non_plainnum[0]=4, non_plainnum[1..5]=64.
REQ-031 Groups 0,11×6 -> plainnum[0..4]=11, plainnum[5]=9, non_plainnum[5]=2, count=64.
REQ-032 First macroblock after reset, key=1 -> original_position[0]=1, [1]=38; inverse mapping restores tags in group order.
REQ-033 Macroblock with no sign bits -> mb_conf_wr pulses, mb_wr stays 0, count=0, all scrambled_group=7.
REQ-034 clk_en=0 during sign_en/macroblock_end -> no counts change, no pulses.
